// File: rtl/fb_scanout.sv
// fb_scanout: pixel-clock framebuffer scan-out engine.
// Fetches palette indices READ_DELAY pixels ahead of the beam, with line and
// frame wrap. Supports integer upscaling by 2**SCALE_LOG2 and colour lookup
// through a writable RGB888 palette. Pixels outside the active area are
// driven with BORDER_RGB.
// Optional feature: define PALETTE_CYCLE_EN to rotate the palette index by one
// entry per frame while cycle_en is high. Without the macro, cycle_en is ignored
// and no offset adder is built.

module fb_scanout #(
    parameter int unsigned WIDTH      = 1280,
    parameter int unsigned HEIGHT     = 720,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned DATA_BITS  = 4,
    parameter int unsigned READ_DELAY = 2,
    parameter int unsigned CX_BITS    = 11,
    parameter int unsigned CY_BITS    = 10,
    parameter int unsigned ADDR_BITS  = 20,
    parameter logic [23:0] BORDER_RGB = 24'h0
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic [CX_BITS-1:0]   cx,
    input  logic [CY_BITS-1:0]   cy,
    input  logic [CX_BITS-1:0]   frame_width,
    input  logic [CY_BITS-1:0]   frame_height,
    output logic                 read_en,
    output logic [ADDR_BITS-1:0] read_addr,
    input  logic [DATA_BITS-1:0] read_data,
    input  logic                 pal_we,
    input  logic [DATA_BITS-1:0] pal_waddr,
    input  logic [23:0]          pal_wdata,
    input  logic                 cycle_en,
    output logic [23:0]          rgb
);

    localparam int unsigned PAL_DEPTH = 1 << DATA_BITS;
    localparam int unsigned SRC_W     = WIDTH >> SCALE_LOG2;
    localparam int unsigned LX_BITS   = CX_BITS + 1;
    localparam int unsigned LY_BITS   = CY_BITS + 1;
    localparam int unsigned RAMP_SH   = 8 - DATA_BITS;

    // Lookahead beam position, one bit wider than the inputs to hold the carry
    logic [LX_BITS-1:0] lx_sum;
    logic [LY_BITS-1:0] ly_sum;
    logic               wrap_x;
    logic [LX_BITS-1:0] look_x;
    logic [LY_BITS-1:0] look_y;

    // Fetch decode
    logic                 fetch_en;
    logic [LX_BITS-1:0]   src_x;
    logic [LY_BITS-1:0]   src_y;
    logic [ADDR_BITS-1:0] fetch_addr;

    // Registered state
    logic                  read_en_q,   read_en_d;
    logic [ADDR_BITS-1:0]  read_addr_q, read_addr_d;
    logic [READ_DELAY-1:0] act_q,       act_d;
    logic [23:0]           rgb_q,       rgb_d;
    logic [23:0]           pal_q [PAL_DEPTH];
    logic [23:0]           pal_d [PAL_DEPTH];

    // Palette lookup index after optional rotation
    logic [DATA_BITS-1:0]  pix_idx;

    assign read_en   = read_en_q;
    assign read_addr = read_addr_q;
    assign rgb       = rgb_q;

    // Beam position READ_DELAY pixels ahead, wrapping across line and frame ends
    always_comb begin
        lx_sum = {1'b0, cx} + LX_BITS'(READ_DELAY);
        wrap_x = (lx_sum >= {1'b0, frame_width});
        look_x = lx_sum;
        if (wrap_x) begin
            look_x = lx_sum - {1'b0, frame_width};
        end
        ly_sum = {1'b0, cy} + LY_BITS'(wrap_x);
        look_y = ly_sum;
        if (ly_sum >= {1'b0, frame_height}) begin
            look_y = '0;
        end
    end

    // Decide whether the lookahead pixel is visible and form its source address
    always_comb begin
        fetch_en   = (look_x < LX_BITS'(WIDTH)) && (look_y < LY_BITS'(HEIGHT));
        src_x      = look_x >> SCALE_LOG2;
        src_y      = look_y >> SCALE_LOG2;
        fetch_addr = ADDR_BITS'(src_y) * ADDR_BITS'(SRC_W) + ADDR_BITS'(src_x);
    end

    // Next fetch strobe/address; address holds while the lookahead is in blanking
    always_comb begin
        read_en_d   = fetch_en;
        read_addr_d = read_addr_q;
        if (fetch_en) begin
            read_addr_d = fetch_addr;
        end
    end

    // Active flag shifts alongside the RAM pipeline so it lines up with read_data
    always_comb begin
        act_d = READ_DELAY'({act_q, read_en_q});
    end

`ifdef PALETTE_CYCLE_EN
    logic [DATA_BITS-1:0] offset_q, offset_d;

    // Advance the rotation once per frame at the top-left beam position
    always_comb begin
        offset_d = offset_q;
        if ((cx == '0) && (cy == '0) && cycle_en) begin
            offset_d = offset_q + DATA_BITS'(1);
        end
    end

    // Rotation offset register
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end

    assign pix_idx = read_data + offset_q;
`else
    logic unused_cycle_en;
    assign unused_cycle_en = cycle_en;
    assign pix_idx         = read_data;
`endif

    // Colour of the pixel whose index arrives this cycle
    always_comb begin
        rgb_d = BORDER_RGB;
        if (act_q[READ_DELAY-1]) begin
            rgb_d = pal_q[pix_idx];
        end
    end

    // Palette update; a lookup in the write cycle still sees the old entry
    always_comb begin
        pal_d = pal_q;
        if (pal_we) begin
            pal_d[pal_waddr] = pal_wdata;
        end
    end

    // Fetch, alignment and output registers
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            read_en_q   <= 1'b0;
            read_addr_q <= '0;
            act_q       <= '0;
            rgb_q       <= '0;
        end else begin
            read_en_q   <= read_en_d;
            read_addr_q <= read_addr_d;
            act_q       <= act_d;
            rgb_q       <= rgb_d;
        end
    end

    // Palette storage, reset to a grey ramp
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int i = 0; i < int'(PAL_DEPTH); i++) begin
                pal_q[i] <= {3{8'(i << RAMP_SH)}};
            end
        end else begin
            pal_q <= pal_d;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: a driver applies directed and random beam
// positions, palette writes and resets, and pushes the expected read strobe,
// read address and colour for every clock; a monitor pops and compares.

module tb_fb_scanout;

    localparam int unsigned WIDTH  = 1280;
    localparam int unsigned HEIGHT = 720;
    localparam int unsigned S      = 0;
    localparam int unsigned DB     = 4;
    localparam int unsigned RD     = 2;
    localparam int unsigned CXB    = 11;
    localparam int unsigned CYB    = 10;
    localparam int unsigned AB     = 20;
    localparam logic [23:0] BORDER = 24'h0A0B0C;
    localparam int unsigned FW     = 1650;
    localparam int unsigned FH     = 750;
    localparam int unsigned N      = 1 << DB;

    logic           clk_pixel;
    logic           reset;
    logic [CXB-1:0] cx;
    logic [CYB-1:0] cy;
    logic [CXB-1:0] frame_width;
    logic [CYB-1:0] frame_height;
    logic           read_en;
    logic [AB-1:0]  read_addr;
    logic [DB-1:0]  read_data;
    logic           pal_we;
    logic [DB-1:0]  pal_waddr;
    logic [23:0]    pal_wdata;
    logic           cycle_en;
    logic [23:0]    rgb;

    fb_scanout #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .SCALE_LOG2(S), .DATA_BITS(DB),
        .READ_DELAY(RD), .CX_BITS(CXB), .CY_BITS(CYB), .ADDR_BITS(AB),
        .BORDER_RGB(BORDER)
    ) dut (
        .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy),
        .frame_width(frame_width), .frame_height(frame_height),
        .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .cycle_en(cycle_en), .rgb(rgb)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Framebuffer contents as a fixed function of the address
    function automatic logic [DB-1:0] ramf(input int unsigned a);
        return DB'(a * 3 + 1 + (a >> 9));
    endfunction

    // Framebuffer read port with READ_DELAY cycles of latency
    logic [DB-1:0] ram_pipe [RD];
    always @(posedge clk_pixel) begin
        for (int i = RD - 1; i > 0; i--) ram_pipe[i] <= ram_pipe[i-1];
        ram_pipe[0] <= read_en ? ramf(32'(read_addr)) : '0;
    end
    assign read_data = ram_pipe[RD-1];

    typedef struct {
        logic [23:0]   rgb;
        logic          ren;
        logic [AB-1:0] addr;
    } exp_t;

    typedef struct {
        bit            act;
        logic [DB-1:0] data;
    } samp_t;

    exp_t  sb_q [$];
    samp_t lat_q [$];
    logic [23:0] pal_m [N];
    int unsigned off_m;
    logic [AB-1:0] addr_m;
    int n_cmp;
    int n_bad;

    function automatic void pal_ramp();
        for (int i = 0; i < int'(N); i++) pal_m[i] = {3{8'(i << (8 - DB))}};
    endfunction

    // One clock: predict the outputs after the coming edge, then drive inputs
    task automatic step(input bit rst, input int unsigned x, input int unsigned y,
                        input bit we, input int unsigned wa, input logic [23:0] wd,
                        input bit ce);
        exp_t e;
        samp_t s;
        int unsigned lx, ly;
        bit vis;
        int unsigned a;
        @(negedge clk_pixel);
        s = lat_q.pop_front();
        if (rst) e.rgb = 24'h0;
        else if (s.act) e.rgb = pal_m[(int'(s.data) + off_m) % N];
        else e.rgb = BORDER;
        if (rst) begin
            for (int i = 0; i < lat_q.size(); i++) lat_q[i].act = 1'b0;
        end
        lx = x + RD;
        ly = y;
        if (lx >= FW) begin
            lx = lx - FW;
            ly = ly + 1;
        end
        if (ly >= FH) ly = 0;
        vis = (lx < WIDTH) && (ly < HEIGHT);
        a = ((ly >> S) * (WIDTH >> S) + (lx >> S)) % (1 << AB);
        if (rst) begin
            addr_m = '0;
            e.ren  = 1'b0;
        end else begin
            e.ren = vis;
            if (vis) addr_m = AB'(a);
        end
        e.addr = addr_m;
        s.act  = vis && !rst;
        s.data = ramf(a);
        lat_q.push_back(s);
        if (rst) begin
            pal_ramp();
            off_m = 0;
        end else begin
            if (we) pal_m[wa % N] = wd;
`ifdef PALETTE_CYCLE_EN
            if (x == 0 && y == 0 && ce) off_m = (off_m + 1) % N;
`endif
        end
        sb_q.push_back(e);
        reset     = rst;
        cx        = CXB'(x);
        cy        = CYB'(y);
        pal_we    = we;
        pal_waddr = DB'(wa);
        pal_wdata = wd;
        cycle_en  = ce;
    endtask

    // Monitor: compare every output cycle against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_pixel);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (rgb !== e.rgb) begin
                    n_bad++;
                    $display("FAIL rgb t=%0t: got %h expected %h", $time, rgb, e.rgb);
                end
                n_cmp++;
                if (read_en !== e.ren) begin
                    n_bad++;
                    $display("FAIL read_en t=%0t: got %b expected %b", $time, read_en, e.ren);
                end
                n_cmp++;
                if (read_addr !== e.addr) begin
                    n_bad++;
                    $display("FAIL read_addr t=%0t: got %0d expected %0d", $time, read_addr, e.addr);
                end
            end
        end
    end

    initial begin
        int unsigned bx, by, r;
        int waited;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        cx = '0;
        cy = '0;
        frame_width  = CXB'(FW);
        frame_height = CYB'(FH);
        pal_we = 1'b0;
        pal_waddr = '0;
        pal_wdata = '0;
        cycle_en = 1'b0;
        pal_ramp();
        off_m = 0;
        addr_m = '0;
        for (int i = 0; i <= int'(RD); i++) lat_q.push_back('{act: 1'b0, data: '0});

        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        // Top-left fetch and a short run along the line
        for (int i = 0; i < 6; i++) step(0, i, 0, 0, 0, 0, 0);
        // Lookahead into right blanking, line wrap, frame wrap, border
        step(0, 1278, 5, 0, 0, 0, 0);
        step(0, 1279, 5, 0, 0, 0, 0);
        step(0, 1648, 5, 0, 0, 0, 0);
        step(0, 1649, 749, 0, 0, 0, 0);
        step(0, 1300, 100, 0, 0, 0, 0);
        step(0, 1300, 100, 0, 0, 0, 0);
        // Palette write then lookup of entry 5 (address 12 holds index 5)
        step(0, 1300, 100, 1, 5, 24'h123456, 0);
        step(0, 10, 0, 0, 0, 0, 0);
        step(0, 1300, 100, 0, 0, 0, 0);
        step(0, 1300, 100, 0, 0, 0, 0);
        // Write entry 5 in the very cycle it is looked up: old colour expected
        step(0, 1300, 100, 1, 5, 24'h654321, 0);
        step(0, 10, 0, 0, 0, 0, 0);
        step(0, 1300, 100, 0, 0, 0, 0);
        step(0, 1300, 100, 0, 0, 0, 0);
        step(0, 1300, 100, 0, 0, 0, 0);
        // Mid-frame reset while scanning line 200
        for (int i = 396; i < 412; i++) step(i == 400, i, 200, 0, 0, 0, 0);

        // Randomised scanning with jumps, palette writes and rare resets
        bx = 0;
        by = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                bx = $urandom_range(0, FW - 1);
                by = $urandom_range(0, FH - 1);
            end else if (r < 15) begin
                bx = FW - 1 - $urandom_range(0, 3);
                by = (r < 13) ? FH - 1 : $urandom_range(0, FH - 1);
            end else begin
                bx = bx + 1;
                if (bx >= FW) begin
                    bx = 0;
                    by = (by + 1 >= FH) ? 0 : by + 1;
                end
            end
            step($urandom_range(0, 199) == 0, bx, by,
                 $urandom_range(0, 7) == 0, $urandom_range(0, N - 1),
                 24'($urandom), 1'($urandom_range(0, 1)));
        end

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(negedge clk_pixel);
            waited++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
